// File: rtl/zeus_timer_pkg.sv
// Shared definitions for the Zeus interval timer: register addresses, ctrl layout
// and the prescaler mask helper.
package zeus_timer_pkg;

  localparam logic [1:0] TMR_LO   = 2'd0;
  localparam logic [1:0] TMR_HI   = 2'd1;
  localparam logic [1:0] TMR_CTRL = 2'd2;
  localparam logic [1:0] TMR_STAT = 2'd3;

  localparam int unsigned EN    = 7;
  localparam int unsigned CONT  = 6;
  localparam int unsigned IE    = 5;
  localparam int unsigned PS_HI = 2;
  localparam int unsigned PS_LO = 0;

  typedef struct packed {
    logic       en;
    logic       cont;
    logic       ie;
    logic [1:0] spare;
    logic [2:0] ps;
  } ctrl_t;

  // Low PS bits of the prescaler that must all be ones for a tick.
  function automatic logic [6:0] ps_mask(input logic [2:0] ps);
    logic [7:0] m;
    m = (8'd1 << ps) - 8'd1;
    return m[6:0];
  endfunction

endpackage

// File: rtl/bus_write_strobe.sv
// Synchronises the asynchronous phi2 bus clock and turns each falling edge of a
// selected write cycle into a single-cycle write strobe.
module bus_write_strobe #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic phi2,
  input  logic cs_n,
  input  logic write_enable,
  output logic wr_stb
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], phi2};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign wr_stb = prev_q & ~sync_q[SYNC_STAGES-1] & ~cs_n & write_enable;

endmodule

// File: rtl/interval_timer.sv
// 16-bit programmable down-counting interval timer with prescaler, one-shot and
// continuous modes, and a sticky expiry flag driving an active-low interrupt.
module interval_timer
  import zeus_timer_pkg::*;
#(
  parameter logic [15:0] RELOAD_RESET     = 16'hFFFF,
  parameter int unsigned PHI2_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       phi2,
  input  logic       write_enable,
  input  logic [1:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq_n
);

  logic [15:0] reload_q, reload_d, count_q, count_d;
  logic [7:0]  lo_q, lo_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        flag_q, flag_d, irq_n_q, irq_n_d;
  logic [6:0]  presc_q, presc_d, mask;
  logic [7:0]  ctrl_byte;
  logic        wr_stb, tick, expire;

  bus_write_strobe #(
    .SYNC_STAGES(PHI2_SYNC_STAGES)
  ) u_wr_stb (
    .clk          (clk),
    .reset_n      (reset_n),
    .phi2         (phi2),
    .cs_n         (cs_n),
    .write_enable (write_enable),
    .wr_stb       (wr_stb)
  );

  assign ctrl_byte = ctrl_q;
  assign mask      = ps_mask(ctrl_byte[PS_HI:PS_LO]);
  assign tick      = ctrl_byte[EN] && ((presc_q & mask) == mask);

  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    lo_d     = lo_q;
    ctrl_d   = ctrl_q;
    flag_d   = flag_q;
    presc_d  = ctrl_byte[EN] ? presc_q + 7'd1 : 7'd0;
    expire   = 1'b0;
    irq_n_d  = ~(flag_q & ctrl_byte[IE]);

    // A reload write takes priority over any tick in the same cycle.
    if (wr_stb && address == TMR_HI) begin
      reload_d = {data_in, lo_q};
      count_d  = {data_in, lo_q};
      presc_d  = 7'd0;
    end else if (tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        expire  = 1'b1;
        count_d = reload_q;
        if (!ctrl_byte[CONT]) ctrl_d.en = 1'b0;
      end
    end

    if (wr_stb && address == TMR_LO)   lo_d   = data_in;
    if (wr_stb && address == TMR_CTRL) ctrl_d = ctrl_t'(data_in);
    if (wr_stb && address == TMR_STAT && data_in[0]) flag_d = 1'b0;
    if (expire) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= RELOAD_RESET;
      count_q  <= RELOAD_RESET;
      lo_q     <= 8'h00;
      ctrl_q   <= '0;
      flag_q   <= 1'b0;
      presc_q  <= 7'd0;
      irq_n_q  <= 1'b1;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      lo_q     <= lo_d;
      ctrl_q   <= ctrl_d;
      flag_q   <= flag_d;
      presc_q  <= presc_d;
      irq_n_q  <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;

  always_comb begin
    data_out = 8'h00;
    unique case (address)
      TMR_LO:   data_out = count_q[7:0];
      TMR_HI:   data_out = count_q[15:8];
      TMR_CTRL: data_out = ctrl_byte;
      TMR_STAT: data_out = {6'b0, ctrl_byte[EN], flag_q};
    endcase
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios plus random register
// traffic, compared every cycle against a behavioural model of the timer.
module tb_interval_timer;

  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       phi2 = 1'b0;
  logic       write_enable = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       irq_n;

  always #5 clk = ~clk;

  interval_timer #(
    .RELOAD_RESET     (16'hFFFF),
    .PHI2_SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cs_n         (cs_n),
    .phi2         (phi2),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .irq_n        (irq_n)
  );

  int compared = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [15:0] m_reload, m_count;
  logic [7:0]  m_lo, m_ctrl;
  bit          m_flag, m_irq_n;
  int          m_pcnt;
  // Pending bus write: lands a fixed number of clk edges after phi2 falls
  int          p_cnt = 0;
  bit          p_write = 1'b0;
  logic [1:0]  p_addr = 2'd0;
  logic [7:0]  p_data = 8'h00;

  task automatic model_reset();
    m_reload = 16'hFFFF;
    m_count  = 16'hFFFF;
    m_lo     = 8'h00;
    m_ctrl   = 8'h00;
    m_flag   = 1'b0;
    m_irq_n  = 1'b1;
    m_pcnt   = 0;
    p_cnt    = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [1:0] a, input logic [7:0] d);
    int period, n_pcnt;
    bit tick, load, expire, n_flag, n_irq;
    logic [15:0] n_count, n_reload;
    logic [7:0]  n_ctrl, n_lo;
    period   = 1 << int'(m_ctrl[2:0]);
    tick     = m_ctrl[7] && ((m_pcnt % period) == period - 1);
    load     = wr && a == 2'd1;
    expire   = tick && !load && m_count == 16'd0;
    n_pcnt   = m_ctrl[7] ? (m_pcnt + 1) % 128 : 0;
    n_irq    = !(m_flag && m_ctrl[5]);
    n_count  = m_count;
    n_reload = m_reload;
    n_ctrl   = m_ctrl;
    n_lo     = m_lo;
    n_flag   = m_flag;
    if (load) begin
      n_reload = {d, m_lo};
      n_count  = {d, m_lo};
      n_pcnt   = 0;
    end else if (tick) begin
      n_count = (m_count == 16'd0) ? m_reload : m_count - 16'd1;
    end
    if (expire && !m_ctrl[6]) n_ctrl[7] = 1'b0;
    if (wr && a == 2'd0) n_lo = d;
    if (wr && a == 2'd2) n_ctrl = d;
    if (wr && a == 2'd3 && d[0]) n_flag = 1'b0;
    if (expire) n_flag = 1'b1;
    m_reload = n_reload;
    m_count  = n_count;
    m_ctrl   = n_ctrl;
    m_lo     = n_lo;
    m_flag   = n_flag;
    m_pcnt   = n_pcnt;
    m_irq_n  = n_irq;
  endtask

  function automatic logic [7:0] model_read(input int a);
    case (a)
      0:       return m_count[7:0];
      1:       return m_count[15:8];
      2:       return m_ctrl;
      default: return {6'b0, m_ctrl[7], m_flag};
    endcase
  endfunction

  task automatic cyc();
    bit wr;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      wr = 1'b0;
      if (p_cnt > 0) begin
        p_cnt--;
        wr = (p_cnt == 0) && p_write;
      end
      model_edge(wr, p_addr, p_data);
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_irq(input string tag);
    check(tag, {7'b0, irq_n}, {7'b0, m_irq_n});
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("%s_r%0d", tag, a), data_out, model_read(a));
    end
    check_irq({tag, "_irq"});
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc();
      check_regs(tag);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input bit cs,
                           input int hold);
    address      = a;
    data_in      = d;
    cs_n         = cs;
    write_enable = 1'b1;
    phi2         = 1'b1;
    for (int i = 0; i < hold; i++) cyc();
    phi2    = 1'b0;
    p_cnt   = SYNC + 1;
    p_addr  = a;
    p_data  = d;
    p_write = !cs;
    for (int i = 0; i < SYNC + 3; i++) begin
      cyc();
      check_irq("wr_irq");
    end
    cs_n         = 1'b1;
    write_enable = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_write(a, d, 1'b0, 3);
  endtask

  task automatic read_const(input string tag, input logic [1:0] a, input logic [7:0] exp);
    address = a;
    #1;
    check(tag, data_out, exp);
  endtask

  initial begin
    logic [1:0] ra;
    logic [7:0] rd;
    model_reset();
    repeat (2) cyc();
    @(negedge clk);
    reset_n = 1'b1;
    check_regs("rst");
    read_const("rst_hi", 2'd1, 8'hFF);

    // Continuous, reload 3, PS 0: expiry every 4 cycles
    wr(2'd0, 8'h03);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'hE0);
    run(12, "cont");

    // One-shot, reload 2, PS 2: expiry after 12 cycles then stops
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h02);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'hA2);
    run(16, "oneshot");
    read_const("os_stat", 2'd3, 8'h01);
    read_const("os_cnt", 2'd0, 8'h02);
    check("os_irq", {7'b0, irq_n}, 8'h00);
    wr(2'd3, 8'h01);
    run(2, "os_clr");
    check("os_irq_clr", {7'b0, irq_n}, 8'h01);

    // Reload 0, PS 0: every tick expires, so a flag clear always collides with a set
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'hE0);
    wr(2'd3, 8'h01);
    run(2, "coll");
    read_const("coll_stat", 2'd3, 8'h03);
    check("coll_irq", {7'b0, irq_n}, 8'h00);

    // IE off with flag set, then IE back on
    wr(2'd2, 8'h00);
    run(2, "ieoff");
    read_const("ieoff_stat", 2'd3, 8'h01);
    check("ieoff_irq", {7'b0, irq_n}, 8'h01);
    wr(2'd2, 8'h20);
    run(1, "ieon");
    check("ieon_irq", {7'b0, irq_n}, 8'h00);

    // Long phi2 high phase yields one write; deselected write is ignored
    wr(2'd0, 8'h11);
    bus_write(2'd1, 8'h55, 1'b0, 10);
    run(1, "phi2");
    read_const("phi2_hi", 2'd1, 8'h55);
    read_const("phi2_lo", 2'd0, 8'h11);
    bus_write(2'd1, 8'h77, 1'b1, 3);
    run(1, "nocs");
    read_const("nocs_hi", 2'd1, 8'h55);

    // Random register traffic
    for (int i = 0; i < 60; i++) begin
      ra = 2'($urandom_range(0, 3));
      rd = 8'($urandom);
      if (ra == 2'd1 && $urandom_range(0, 3) != 0) rd = 8'h00;
      if (ra == 2'd2) rd[2:0] = 3'($urandom_range(0, 3));
      wr(ra, rd);
      run($urandom_range(1, 12), "rnd");
    end

    // Reset in the middle of a count with the flag set
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'hC0);
    wr(2'd0, 8'h23);
    wr(2'd1, 8'h01);
    wr(2'd2, 8'hA7);
    run(3, "pre_rst");
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_irq", {7'b0, irq_n}, 8'h01);
    read_const("arst_lo", 2'd0, 8'hFF);
    read_const("arst_hi", 2'd1, 8'hFF);
    read_const("arst_ctrl", 2'd2, 8'h00);
    read_const("arst_stat", 2'd3, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    run(3, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
